// File: rtl/rom_streamer.sv
// rom_streamer: issues the ROM read addresses for a requested burst and returns
// the fetched words on a valid/ready stream through a 2-entry FIFO buffer.
// Ports: clk/rst (sync, active-high); start/base_addr/length request a burst;
//        addr_rd/rd_en/rom_data go to the synchronous-read ROM;
//        out_valid/out_ready/out_data form the output stream;
//        busy is high while a burst runs, and done pulses once when it ends.
// Latency: first word is valid 2 cycles after the start edge. Throughput is 1 word/cycle.
// Backpressure: fetching stalls when buffered plus in-flight words would exceed 2 entries.
module rom_streamer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DEPTH_LOG-1:0] base_addr,
  input  logic [DEPTH_LOG:0]   length,
  output logic [DEPTH_LOG-1:0] addr_rd,
  output logic                 rd_en,
  input  logic [WIDTH-1:0]     rom_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  localparam logic [DEPTH_LOG-1:0] LAST_ADDR = DEPTH_LOG'(DEPTH - 1);
  localparam logic [DEPTH_LOG:0]   CNT_ONE   = (DEPTH_LOG+1)'(1);

  state_e               state_q, state_d;
  logic [DEPTH_LOG-1:0] addr_q, addr_d;
  logic [DEPTH_LOG:0]   issue_q, issue_d;
  logic [DEPTH_LOG:0]   deliver_q, deliver_d;
  logic                 inflight_q;
  logic [1:0]           occ_q, occ_d;
  logic [WIDTH-1:0]     buf0_q, buf0_d;   // head entry
  logic [WIDTH-1:0]     buf1_q, buf1_d;
  logic                 pop, push, fetch;
  logic [2:0]           committed;

  assign pop  = (occ_q != 2'd0) && out_ready;
  // A word fetched last cycle is on rom_data now and is captured this edge.
  assign push = inflight_q;

  // Slots still claimed after this edge, ignoring any new fetch. A fetch is
  // allowed only if that leaves room, so occupancy can never reach 3.
  assign committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fetch     = (state_q == RUN) && (issue_q != '0) && (committed < 3'd2);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    issue_d   = issue_q;
    deliver_d = deliver_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          issue_d   = length;
          deliver_d = length;
          state_d   = (length == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (fetch) begin
          // Explicit wrap so non-power-of-two depths stay in range.
          addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          issue_d = issue_q - 1'b1;
        end
        if (pop) begin
          deliver_d = deliver_q - 1'b1;
          if (deliver_q == CNT_ONE) state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Two-entry FIFO: buf0 is always the head, and buf1 is valid only when occ=2.
  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (push && !pop) begin
      if (occ_q == 2'd0) buf0_d = rom_data;
      else               buf1_d = rom_data;
      occ_d = occ_q + 2'd1;
    end else if (!push && pop) begin
      buf0_d = buf1_q;
      occ_d  = occ_q - 2'd1;
    end else if (push && pop) begin
      if (occ_q == 2'd1) begin
        buf0_d = rom_data;
      end else begin
        buf0_d = buf1_q;
        buf1_d = rom_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      issue_q    <= '0;
      deliver_q  <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      deliver_q  <= deliver_d;
      inflight_q <= fetch;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

  assign addr_rd   = addr_q;
  assign rd_en     = fetch;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf0_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == FINISH);

endmodule

// File: tb/tb_rom_streamer.sv
// Bench for rom_streamer with a synchronous-read ROM holding data[i] = i + 0x10.
// Expected addresses and words are queued when a burst starts and popped on each fetch and pop.
module tb_rom_streamer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int DL    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [DL-1:0]    base_addr;
  logic [DL:0]      length;
  logic [DL-1:0]    addr_rd;
  logic             rd_en;
  logic [WIDTH-1:0] rom_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             done;

  rom_streamer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_LOG(DL)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .addr_rd(addr_rd), .rd_en(rd_en), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] rom_mem [DEPTH];
  always @(posedge clk) rom_data <= rom_mem[addr_rd];

  int checks = 0;
  int errors = 0;
  logic [DL-1:0]    exp_addr [$];
  logic [WIDTH-1:0] exp_dat  [$];
  int cyc = 0, issued = 0, popped = 0;
  int start_cyc, first_vld_cyc, last_pop_cyc, done_cyc, done_cnt;
  logic             held_vld = 1'b0;
  logic [WIDTH-1:0] held_dat;
  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Samples the current cycle's outputs after the inputs have settled.
  task automatic observe();
    #1;
    chk("outstanding_le_2", ((issued - popped) <= 2), 1);
    if (rd_en) begin
      checks++;
      assert (exp_addr.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_fetch observed=%0h expected=none", addr_rd);
      end
      if (exp_addr.size() != 0) chk("addr_rd", addr_rd, exp_addr.pop_front());
      issued++;
    end
    if (out_valid && held_vld) chk("stall_stable", out_data, held_dat);
    if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_dat.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_word observed=%0h expected=none", out_data);
      end
      if (exp_dat.size() != 0) chk("out_data", out_data, exp_dat.pop_front());
      popped++;
      last_pop_cyc = cyc;
    end
    held_vld = out_valid && !out_ready;
    held_dat = out_data;
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
      chk("busy_low_on_done", busy, 0);
    end
    cyc++;
  endtask

  task automatic step();
    observe();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_addr.delete();
    exp_dat.delete();
    issued = 0;
    popped = 0;
    held_vld = 1'b0;
    #1;
    chk("rst_addr_rd", addr_rd, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  task automatic start_burst(input int base, input int len);
    start = 1'b1;
    base_addr = DL'(base);
    length = (DL+1)'(len);
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(DL'((base + i) % DEPTH));
      exp_dat.push_back(WIDTH'(((base + i) % DEPTH) + 16));
    end
    start_cyc = cyc;
    first_vld_cyc = -1;
    last_pop_cyc = -1;
    done_cyc = -1;
    done_cnt = 0;
    step();
    // Scramble the request inputs to confirm they were latched at the start edge.
    start = 1'b0;
    base_addr = 4'd9;
    length = 5'd3;
  endtask

  // mode 0: out_ready held high; mode 1: out_ready follows the toggle pattern.
  task automatic wait_done(input string tag, input int len, input int mode, input int maxc);
    int k = 0;
    while (done_cyc < 0 && k < maxc) begin
      out_ready = (mode == 0) ? 1'b1 : pat[k % 7];
      step();
      k++;
    end
    checks++;
    assert (done_cyc >= 0) else begin
      errors++;
      $error("FAIL %s_done_timeout observed=none expected=done within %0d cycles", tag, maxc);
    end
    chk({tag, "_first_word_latency"}, first_vld_cyc - start_cyc, 3);
    chk({tag, "_done_after_last_pop"}, done_cyc - last_pop_cyc, 1);
    chk({tag, "_words_left"}, exp_dat.size(), 0);
    chk({tag, "_fetches_left"}, exp_addr.size(), 0);
    chk({tag, "_pop_count"}, popped, len);
    if (mode == 0) chk({tag, "_throughput"}, last_pop_cyc - first_vld_cyc, len - 1);
    out_ready = 1'b1;
    step();
    step();
    chk({tag, "_done_one_cycle"}, done_cnt, 1);
    chk({tag, "_idle_busy"}, busy, 0);
    issued = 0;
    popped = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = WIDTH'(i + 16);
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    out_ready = 1'b0;
    do_reset();

    // Basic burst: 0x13..0x16.
    out_ready = 1'b1;
    start_burst(3, 4);
    wait_done("basic", 4, 0, 40);

    // Address wrap: 0x1E, 0x1F, 0x10, 0x11.
    start_burst(14, 4);
    wait_done("wrap", 4, 0, 40);

    // Backpressure with the toggle pattern.
    start_burst(0, 8);
    wait_done("bp", 8, 1, 100);

    // Full-depth burst with wrap.
    start_burst(5, 16);
    wait_done("full", 16, 0, 60);

    // length=0: no fetch, no word, and done in the next cycle. A start during FINISH is ignored.
    start_burst(5, 0);
    start = 1'b1;
    base_addr = 4'd7;
    length = 5'd1;
    step();
    start = 1'b0;
    step();
    step();
    chk("len0_done_cycle", done_cyc - start_cyc, 1);
    chk("len0_done_count", done_cnt, 1);
    chk("len0_no_valid", first_vld_cyc, -1);
    chk("len0_no_fetch", issued, 0);

    // Start pulsed mid-burst is ignored.
    start_burst(1, 6);
    out_ready = 1'b1;
    step();
    step();
    start = 1'b1;
    base_addr = 4'd9;
    length = 5'd2;
    step();
    step();
    start = 1'b0;
    wait_done("midstart", 6, 0, 40);

    // Reset one cycle after the first fetch.
    start_burst(0, 5);
    out_ready = 1'b1;
    step();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_no_valid", out_valid, 0);
      chk("post_rst_no_fetch", rd_en, 0);
      step();
    end
    start_burst(2, 2);
    wait_done("after_rst", 2, 0, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_streamer.md
# rom_streamer

Sequencer that sits directly upstream of the synchronous-read ROM: it generates the ROM read address stream for a requested burst, absorbs the ROM's one-cycle read latency, and presents the fetched words on a valid/ready output stream with full backpressure support. A 2-entry output buffer lets the block sustain one word per cycle while the consumer is ready and lose no data when it stalls.

## Interface
- WIDTH, 8: ROM word width in bits.
- DEPTH, 16: number of ROM words.
- DEPTH_LOG, $clog2(DEPTH): ROM address width.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  burst request, sampled only when busy=0.
- base_addr  input  DEPTH_LOG  first ROM address of the burst.
- length  input  DEPTH_LOG+1  number of words, 0..DEPTH.
- addr_rd  output  DEPTH_LOG  ROM read address; drives the ROM's addr_rd.
- rd_en  output  1  high in cycles where addr_rd is a real fetch.
- rom_data  input  WIDTH  ROM data_out; valid the cycle after the fetch edge.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  WIDTH  fetched word, in address order.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse when a burst completes.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE: busy=0. start=1 latches base_addr into the address counter and length into the remaining-to-issue and remaining-to-deliver counters. length≠0 -> RUN. length=0 -> FINISH with no words fetched.
- RUN: busy=1. The fetch condition is remaining-to-issue≠0 and (occupancy + inflight − pop) < 2.
  - pop = out_valid & out_ready.
  - inflight = rd_en from the previous cycle.
  - occupancy = buffer entries, 0..2.
- Fetch: rd_en=1, and addr_rd is the current address counter. On the edge, the counter advances and remaining-to-issue decrements.
- Address wrap: after DEPTH−1 the next address is 0, for any DEPTH including non-powers of two.
- Capture: one cycle after a fetch edge, rom_data is written into the buffer at that edge. The buffer is first-in first-out.
- Simultaneous capture and pop: occupancy is unchanged, and order is preserved.
- out_valid = (occupancy≠0). out_data = buffer head, and it is held stable while out_valid=1 and out_ready=0.
- On each pop, remaining-to-deliver decrements. When it reaches 0 -> FINISH.
- FINISH: done=1 for exactly one cycle, busy=0, then IDLE. start is ignored during the FINISH cycle.
- start while busy=1 is ignored, with no effect on the burst in progress.
- Changes to base_addr or length after the start edge have no effect.
- Buffer overflow cannot occur under the fetch condition. The fetch condition must never permit occupancy to exceed 2.
- rst in any state: return to IDLE, flush the buffer, and discard the in-flight fetch. The ROM word returning after reset is not captured.

## Timing
- Reset values: addr_rd=0, rd_en=0, out_valid=0, out_data=0, busy=0, done=0. Occupancy, inflight and all counters are 0.
- Start edge E0: after E0, busy=1, rd_en=1 and addr_rd=base_addr.
- E1: the ROM registers the data.
- E2: the block captures the word; out_valid=1 after E2. Start-to-first-word latency is 2 cycles.
- Throughput: with out_ready held at 1, one word per cycle. N words complete in N+2 cycles after E0, and done pulses in the cycle after the last pop.
- Stall: with out_ready=0, at most 2 words are buffered and rd_en drops. When out_ready rises, the buffered words drain at 1 per cycle and fetching resumes the same cycle.
- length=DEPTH: every address is read exactly once, starting at base_addr with wrap.

## Test plan
- ROM loaded with data[i]=i+0x10, base=3, length=4, out_ready=1:
  - out_data 0x13, 0x14, 0x15, 0x16 on consecutive cycles, the first 2 cycles after the start edge;
  - done 1 cycle after the last beat; busy is low from that cycle on.
- Wrap: same ROM, DEPTH=16, base=14, length=4 -> 0x1E, 0x1F, 0x10, 0x11.
- Backpressure: base=0, length=8, out_ready toggled 1,0,0,1,0,1,1,…:
  - all 8 words 0x10..0x17 arrive in order, none duplicated or dropped;
  - occupancy never exceeds 2, and out_data is stable while stalled.
- length=0 -> no rd_en and no out_valid; done pulses in the cycle after the start edge.
- start pulsed mid-burst with base=9 -> ignored, and the original burst completes unchanged.
- rst asserted 1 cycle after the first fetch of a length=5 burst:
  - next cycle all outputs are at reset values, and no stale word appears;
  - a fresh start with base=2, length=2 yields 0x12, 0x13.
